branch_resolve_unit: RTL

Decode-stage block directly downstream of branch_comparator. It consumes BrEq/BrLT/BrLTU plus decoded control bits, then decides taken/not-taken for B-type, JAL and JALR instructions. It computes the target and issues a registered PC-redirect request to fetch over a valid/ready handshake, holding decode stalled until fetch accepts it. It also flushes the wrong-path IF/ID entry and keeps saturating branch statistics counters.

---
 rtl/branch_resolve_unit_pkg.sv | 24 ++
 rtl/branch_resolve_unit_cond_eval.sv | 32 +++
 rtl/branch_resolve_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit: datapath width, branch
// funct3 encodings and the redirect FSM state type.
package branch_resolve_unit_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] BR_F3_BEQ  = 3'b000;
    localparam logic [2:0] BR_F3_BNE  = 3'b001;
    localparam logic [2:0] BR_F3_BLT  = 3'b100;
    localparam logic [2:0] BR_F3_BGE  = 3'b101;
    localparam logic [2:0] BR_F3_BLTU = 3'b110;
    localparam logic [2:0] BR_F3_BGEU = 3'b111;

    typedef enum logic {
        BR_IDLE    = 1'b0,
        BR_PENDING = 1'b1
    } br_state_e;

    // JALR targets always have bit 0 cleared.
    function automatic logic [DATA_WIDTH-1:0] clear_lsb(input logic [DATA_WIDTH-1:0] addr);
        return {addr[DATA_WIDTH-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational B-type condition evaluation from funct3 and the comparator
// flags. Reserved encodings (010/011) are reported illegal and never taken.
module branch_cond_eval
    import branch_resolve_unit_pkg::*;
(
    input  logic [2:0] funct3_i,
    input  logic       br_eq_i,
    input  logic       br_lt_i,
    input  logic       br_ltu_i,
    output logic       taken_o,
    output logic       illegal_o
);

    // Select the comparator flag (or its inverse) addressed by funct3.
    always_comb begin
        taken_o   = 1'b0;
        illegal_o = 1'b0;
        case (funct3_i)
            BR_F3_BEQ:  taken_o = br_eq_i;
            BR_F3_BNE:  taken_o = ~br_eq_i;
            BR_F3_BLT:  taken_o = br_lt_i;
            BR_F3_BGE:  taken_o = ~br_lt_i;
            BR_F3_BLTU: taken_o = br_ltu_i;
            BR_F3_BGEU: taken_o = ~br_ltu_i;
            default: begin
                taken_o   = 1'b0;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Decode-stage branch resolution: decides taken/not-taken for B-type, JAL
// and JALR, computes the target, and holds a registered redirect request
// to fetch until it is accepted (or killed). Also keeps saturating counts.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid_i,
    input  logic [DATA_WIDTH-1:0] id_pc_i,
    input  logic [DATA_WIDTH-1:0] id_imm_i,
    input  logic [DATA_WIDTH-1:0] rd_data1_i,
    input  logic                  id_branch_i,
    input  logic                  id_jal_i,
    input  logic                  id_jalr_i,
    input  logic [2:0]            id_funct3_i,
    input  logic                  BrEq,
    input  logic                  BrLT,
    input  logic                  BrLTU,
    input  logic                  kill_i,
    input  logic                  fetch_ready_i,
    output logic                  redirect_valid_o,
    output logic [DATA_WIDTH-1:0] redirect_pc_o,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic                  misalign_o,
    output logic                  illegal_br_o,
    output logic [CNT_WIDTH-1:0]  branch_cnt_o,
    output logic [CNT_WIDTH-1:0]  taken_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    br_state_e             state_q;
    logic                  redirect_valid_q;
    logic [DATA_WIDTH-1:0] redirect_pc_q;
    logic                  misalign_q;
    logic                  illegal_q;
    logic [CNT_WIDTH-1:0]  branch_cnt_q;
    logic [CNT_WIDTH-1:0]  taken_cnt_q;

    logic                  cond_taken_s;
    logic                  cond_illegal_s;
    logic                  resolve_s;
    logic                  taken_s;
    logic                  illegal_s;
    logic [DATA_WIDTH-1:0] target_d;
    logic [CNT_WIDTH-1:0]  branch_cnt_d;
    logic [CNT_WIDTH-1:0]  taken_cnt_d;

    branch_cond_eval u_cond (
        .funct3_i (id_funct3_i),
        .br_eq_i  (BrEq),
        .br_lt_i  (BrLT),
        .br_ltu_i (BrLTU),
        .taken_o  (cond_taken_s),
        .illegal_o(cond_illegal_s)
    );

    // Kill suppresses resolution outright; decode is frozen while pending.
    assign resolve_s = id_valid_i & (id_branch_i | id_jal_i | id_jalr_i)
                     & (state_q == BR_IDLE) & ~kill_i;

    // Decode instruction kind (jalr > jal > branch), target and next counts.
    always_comb begin
        taken_s   = 1'b0;
        illegal_s = 1'b0;
        target_d  = id_pc_i + id_imm_i;
        if (id_jalr_i) begin
            taken_s  = 1'b1;
            target_d = clear_lsb(rd_data1_i + id_imm_i);
        end else if (id_jal_i) begin
            taken_s = 1'b1;
        end else begin
            taken_s   = cond_taken_s;
            illegal_s = cond_illegal_s;
        end
        branch_cnt_d = (branch_cnt_q == CNT_MAX) ? branch_cnt_q : branch_cnt_q + CNT_ONE;
        taken_cnt_d  = (taken_cnt_q  == CNT_MAX) ? taken_cnt_q  : taken_cnt_q  + CNT_ONE;
    end

    // Redirect FSM with registered request, pulses and statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= BR_IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= {DATA_WIDTH{1'b0}};
            misalign_q       <= 1'b0;
            illegal_q        <= 1'b0;
            branch_cnt_q     <= {CNT_WIDTH{1'b0}};
            taken_cnt_q      <= {CNT_WIDTH{1'b0}};
        end else begin
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
            if (kill_i) begin
                state_q          <= BR_IDLE;
                redirect_valid_q <= 1'b0;
            end else if (state_q == BR_PENDING) begin
                if (fetch_ready_i) begin
                    state_q          <= BR_IDLE;
                    redirect_valid_q <= 1'b0;
                end else begin
                    state_q          <= BR_PENDING;
                    redirect_valid_q <= 1'b1;
                end
            end else if (resolve_s) begin
                branch_cnt_q <= branch_cnt_d;
                illegal_q    <= illegal_s;
                if (taken_s) begin
                    taken_cnt_q <= taken_cnt_d;
                end
                if (taken_s && target_d[1]) begin
                    misalign_q <= 1'b1;
                end else if (taken_s) begin
                    state_q          <= BR_PENDING;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= target_d;
                end else begin
                    state_q <= BR_IDLE;
                end
            end else begin
                state_q <= BR_IDLE;
            end
        end
    end

    assign stall_o          = (state_q == BR_PENDING);
    assign flush_o          = (state_q == BR_PENDING) & fetch_ready_i & ~kill_i;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign misalign_o       = misalign_q;
    assign illegal_br_o     = illegal_q;
    assign branch_cnt_o     = branch_cnt_q;
    assign taken_cnt_o      = taken_cnt_q;

endmodule
